// File: rtl/sid_waveform_mixer.sv
// Waveform mixer: ANDs the selected voice components into the 12-bit DAC value and
// emulates the floating DAC input (hold, then bitwise fade) when nothing is selected.
package sid;
    typedef enum logic {
        MOS6581 = 1'b0,
        MOS8580 = 1'b1
    } model_e;

    typedef logic [3:0] phase_t;

    localparam int PHI1      = 0;
    localparam int PHI1_PHI2 = 1;
    localparam int PHI2      = 2;
    localparam int PHI2_PHI1 = 3;

    localparam int SEL_TRI   = 0;
    localparam int SEL_SAW   = 1;
    localparam int SEL_PULSE = 2;
    localparam int SEL_NOISE = 3;

    typedef struct packed {
        logic [3:0]  sel;      // {noise, pulse, saw, tri}
        logic [7:0]  noise;
        logic        pulse;
        logic [11:0] saw_tri;
    } waveform_i_t;
endpackage

// Mixes the generator components once per SID cycle into wav_o / osc3 / noise writeback.
// Latency: one clock, outputs change on the clock edge that samples phase[PHI2] high.
// Backpressure: none; the block consumes wav_i unconditionally on every update event.
module sid_waveform_mixer #(
    parameter int TTL_6581 = 'h01D00,
    parameter int TTL_8580 = 'hA2000,
    parameter int TTL_W    = 20
) (
    input  logic              clk,
    input  logic              res_n,
    input  sid::model_e       model,
    input  sid::phase_t       phase,
    input  sid::waveform_i_t  wav_i,
    output logic [11:0]       wav_o,
    output logic [7:0]        osc3,
    output logic [7:0]        noise_wb,
    output logic              noise_wb_en
);
    logic [11:0]      wav_q, wav_d;
    logic [11:0]      mixed, faded;
    logic [TTL_W-1:0] ttl_q, ttl_d, ttl_load, ttl_dec;
    logic [7:0]       wb_q, wb_d;
    logic             wb_en_q, wb_en_d;
    logic             update;
    logic             unused_phase;

    assign update       = phase[sid::PHI2];
    assign unused_phase = ^phase;
    assign ttl_load     = (model == sid::MOS8580) ? TTL_W'(TTL_8580) : TTL_W'(TTL_6581);
    assign ttl_dec      = ttl_q - 1'b1;
    assign faded        = wav_q & (wav_q >> 1);

    always_comb begin
        mixed = 12'hFFF;
        if (wav_i.sel[sid::SEL_TRI])   mixed = mixed & {wav_i.saw_tri[10:0], 1'b0};
        if (wav_i.sel[sid::SEL_SAW])   mixed = mixed & wav_i.saw_tri;
        if (wav_i.sel[sid::SEL_PULSE]) mixed = mixed & {12{wav_i.pulse}};
        if (wav_i.sel[sid::SEL_NOISE]) mixed = mixed & {wav_i.noise, 4'b0000};
    end

    always_comb begin
        wav_d   = wav_q;
        ttl_d   = ttl_q;
        wb_d    = wb_q;
        wb_en_d = 1'b0;
        if (update) begin
            if (wav_i.sel != 4'b0000) begin
                wav_d = mixed;
                ttl_d = ttl_load;
                // Combined noise drags the LFSR taps down to the mixed result.
                if (wav_i.sel[sid::SEL_NOISE] && (wav_i.sel[2:0] != 3'b000)) begin
                    wb_d    = mixed[11:4];
                    wb_en_d = 1'b1;
                end
            end else if (ttl_q != '0) begin
                ttl_d = ttl_dec;
                if (ttl_dec == '0) begin
                    wav_d = faded;
                    // Once fully faded the timer stays parked at zero.
                    if (faded != 12'h000) ttl_d = ttl_load;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            wav_q   <= 12'h000;
            ttl_q   <= '0;
            wb_q    <= 8'hFF;
            wb_en_q <= 1'b0;
        end else begin
            wav_q   <= wav_d;
            ttl_q   <= ttl_d;
            wb_q    <= wb_d;
            wb_en_q <= wb_en_d;
        end
    end

    assign wav_o       = wav_q;
    assign osc3        = wav_q[11:4];
    assign noise_wb    = wb_q;
    assign noise_wb_en = wb_en_q;
endmodule

// File: tb/tb_sid_waveform_mixer.sv
// Bench for sid_waveform_mixer: directed scenarios plus randomized bursts, every clock
// compared against an event-driven reference model of the mixer and floating-output fade.
module tb_sid_waveform_mixer;
    localparam int T6581 = 4;
    localparam int T8580 = 7;
    localparam logic [3:0] S_TRI   = 4'b0001;
    localparam logic [3:0] S_SAW   = 4'b0010;
    localparam logic [3:0] S_PULSE = 4'b0100;
    localparam logic [3:0] S_NOISE = 4'b1000;

    logic             clk;
    logic             res_n;
    sid::model_e      model;
    sid::phase_t      phase;
    sid::waveform_i_t wav_i;
    logic [11:0]      wav_o;
    logic [7:0]       osc3;
    logic [7:0]       noise_wb;
    logic             noise_wb_en;

    int n_chk  = 0;
    int n_pass = 0;
    int ph     = 0;

    // Reference state: value, writeback, and "elapsed SID cycles vs hold period".
    int m_wav, m_wb, m_en, m_period, m_elapsed;
    bit m_armed;

    sid_waveform_mixer #(
        .TTL_6581(T6581),
        .TTL_8580(T8580),
        .TTL_W   (20)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .model      (model),
        .phase      (phase),
        .wav_i      (wav_i),
        .wav_o      (wav_o),
        .osc3       (osc3),
        .noise_wb   (noise_wb),
        .noise_wb_en(noise_wb_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int mix_ref(input logic [3:0] sel, input logic [7:0] nz,
                                   input logic pl, input logic [11:0] st);
        int comp[4];
        int v;
        comp[0] = (int'(st) * 2) % 4096;
        comp[1] = int'(st);
        comp[2] = pl ? 4095 : 0;
        comp[3] = int'(nz) * 16;
        v = 4095;
        for (int i = 0; i < 4; i++)
            if (sel[i]) v = v & comp[i];
        return v;
    endfunction

    function automatic int period_of(input sid::model_e m);
        return (m == sid::MOS8580) ? T8580 : T6581;
    endfunction

    task automatic model_update();
        int others;
        if (!res_n) begin
            m_wav = 0; m_wb = 'hFF; m_en = 0; m_armed = 0;
        end else begin
            m_en = 0;
            if (phase[sid::PHI2]) begin
                if (wav_i.sel != 4'b0000) begin
                    m_wav     = mix_ref(wav_i.sel, wav_i.noise, wav_i.pulse, wav_i.saw_tri);
                    m_armed   = 1;
                    m_period  = period_of(model);
                    m_elapsed = 0;
                    others    = $countones(wav_i.sel) - (wav_i.sel[3] ? 1 : 0);
                    if (wav_i.sel[3] && others > 0) begin
                        m_wb = m_wav / 16;
                        m_en = 1;
                    end
                end else if (m_armed) begin
                    m_elapsed++;
                    if (m_elapsed == m_period) begin
                        m_wav = m_wav & (m_wav / 2);
                        if (m_wav == 0) m_armed = 0;
                        else begin
                            m_period  = period_of(model);
                            m_elapsed = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("wav_o", int'(wav_o), m_wav);
        chk("osc3", int'(osc3), (m_wav / 16) % 256);
        chk("noise_wb", int'(noise_wb), m_wb);
        chk("noise_wb_en", int'(noise_wb_en), m_en);
        @(negedge clk);
        ph    = (ph + 1) % 4;
        phase = sid::phase_t'(4'b0001 << ph);
    endtask

    task automatic set_in(input logic [3:0] sel, input logic [11:0] st,
                          input logic [7:0] nz, input logic pl);
        wav_i.sel     = sel;
        wav_i.saw_tri = st;
        wav_i.noise   = nz;
        wav_i.pulse   = pl;
    endtask

    task automatic run_cycle(input logic [3:0] sel, input logic [11:0] st,
                             input logic [7:0] nz, input logic pl);
        set_in(sel, st, nz, pl);
        repeat (4) step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            run_cycle(4'b0000, 12'($urandom), 8'($urandom), 1'($urandom));
    endtask

    initial begin
        res_n = 1'b0;
        model = sid::MOS6581;
        phase = sid::phase_t'(4'b0001);
        set_in(4'b0000, 12'h000, 8'h00, 1'b0);
        m_wav = 0; m_wb = 'hFF; m_en = 0; m_armed = 0; m_period = T6581; m_elapsed = 0;

        // Reset with arbitrary inputs across several PHI2 events
        for (int i = 0; i < 3; i++)
            run_cycle(4'($urandom), 12'($urandom), 8'($urandom), 1'($urandom));
        chk("rst_wav", int'(wav_o), 0);
        chk("rst_osc3", int'(osc3), 0);
        chk("rst_wb", int'(noise_wb), 'hFF);
        chk("rst_wb_en", int'(noise_wb_en), 0);
        res_n = 1'b1;

        // Selector 0 straight after reset: holds at 0
        idle(3);
        chk("hold_after_rst", int'(wav_o), 0);

        // Sawtooth, then an off-PHI2 change must be ignored
        set_in(S_SAW, 12'hABC, 8'h00, 1'b0);
        repeat (3) step();
        chk("saw_wav", int'(wav_o), 'hABC);
        chk("saw_osc3", int'(osc3), 'hAB);
        wav_i.saw_tri = 12'h555;
        step();
        chk("saw_offphi2", int'(wav_o), 'hABC);

        run_cycle(S_TRI, 12'h801, 8'h00, 1'b0);
        chk("tri_wav", int'(wav_o), 'h002);
        run_cycle(S_PULSE, 12'h000, 8'h00, 1'b1);
        chk("pulse1_wav", int'(wav_o), 'hFFF);
        run_cycle(S_PULSE, 12'hFFF, 8'hFF, 1'b0);
        chk("pulse0_wav", int'(wav_o), 0);

        // Noise + saw writeback strobe, one clock wide
        set_in(S_NOISE | S_SAW, 12'hC3F, 8'hF0, 1'b0);
        repeat (3) step();
        chk("ns_wav", int'(wav_o), 'hC00);
        chk("ns_wb", int'(noise_wb), 'hC0);
        chk("ns_wb_en", int'(noise_wb_en), 1);
        step();
        chk("ns_wb_en_drop", int'(noise_wb_en), 0);

        set_in(S_NOISE, 12'h000, 8'hA5, 1'b1);
        repeat (3) step();
        chk("noise_only_wav", int'(wav_o), 'hA50);
        chk("noise_only_en", int'(noise_wb_en), 0);
        step();

        // Floating fade on the 6581 timer
        run_cycle(S_SAW, 12'hFFF, 8'h00, 1'b0);
        idle(3);
        chk("fade_pre", int'(wav_o), 'hFFF);
        idle(1);
        chk("fade1", int'(wav_o), 'h7FF);
        idle(4);
        chk("fade2", int'(wav_o), 'h3FF);
        idle(44);
        chk("fade_zero", int'(wav_o), 0);
        idle(10);
        chk("fade_stays_zero", int'(wav_o), 0);

        // New selection on the expiry event wins
        run_cycle(S_SAW, 12'hFFF, 8'h00, 1'b0);
        idle(3);
        run_cycle(S_SAW, 12'h123, 8'h00, 1'b0);
        chk("expiry_sel_wins", int'(wav_o), 'h123);

        // Model switch mid-hold affects only the next reload
        run_cycle(S_SAW, 12'hFFF, 8'h00, 1'b0);
        idle(2);
        model = sid::MOS8580;
        idle(2);
        chk("model_sw_fade1", int'(wav_o), 'h7FF);
        idle(6);
        chk("model_sw_hold", int'(wav_o), 'h7FF);
        idle(1);
        chk("model_sw_fade2", int'(wav_o), 'h3FF);

        // Reset mid-fade
        idle(3);
        res_n = 1'b0;
        run_cycle(S_PULSE, 12'h000, 8'h00, 1'b1);
        chk("midfade_rst_wav", int'(wav_o), 0);
        chk("midfade_rst_wb", int'(noise_wb), 'hFF);
        res_n = 1'b1;
        idle(10);
        chk("midfade_rst_hold", int'(wav_o), 0);
        model = sid::MOS6581;

        // Randomized bursts: idle runs of varying length between selections
        for (int b = 0; b < 150; b++) begin
            if ($urandom_range(0, 9) == 0) model = sid::model_e'($urandom_range(0, 1));
            res_n = ($urandom_range(0, 29) != 0);
            set_in(4'($urandom_range(1, 15)), 12'($urandom), 8'($urandom), 1'($urandom));
            for (int s = 0; s < 4; s++) begin
                if (s != sid::PHI2) wav_i.saw_tri = 12'($urandom);
                step();
            end
            res_n = 1'b1;
            idle($urandom_range(0, 12));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
